spi_aes_frame_slave: RTL and testbench

Peripheral end of the bit-per-clock SPI-style link used by the AES test master. It deserializes a `{plaintext, key}` frame from `mosi` and hands the frame to an AES core over a valid/ready handshake. It then serializes `{result, key}` back on `miso`, preceded by a start bit. Each AES unit (cipher or inverse cipher) sits behind one instance; the master runs every instance from the same `clock`, one bit per cycle.

---
 rtl/spi_aes_frame_slave_pkg.sv | 37 +++
 rtl/spi_aes_frame_slave_if.sv | 44 ++++
 rtl/spi_aes_frame_slave_shifter.sv | 36 +++
 rtl/spi_aes_frame_slave.sv | 186 ++++++++++++++++++
 tb/tb_spi_aes_frame_slave.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_aes_frame_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_spi_pkg
// Description : Shared definitions for the SPI-style AES frame slave.
//               Contents: the frame-width function, the controller state
//               encoding, the legal-Nk check and the start-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_spi_pkg;

    // The level driven on miso for one cycle ahead of every response frame.
    localparam logic c_START_BIT = 1'b1;

    // The bit counter must hold values up to the widest frame (Nk=8, 384).
    localparam int c_CNT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX        = 3'd1,
        ST_CORE_REQ  = 3'd2,
        ST_CORE_WAIT = 3'd3,
        ST_TX_START  = 3'd4,
        ST_TX        = 3'd5
    } state_t;

    // Frame width is one 128-bit block followed by the key.
    function automatic int frame_width(input int nk);
        return 128 + 32 * nk;
    endfunction

    // AES only defines 128-, 192- and 256-bit keys.
    function automatic bit nk_is_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_aes_frame_slave_if.sv
`default_nettype none
// ============================================================================
// Interface   : spi_aes_frame_slave_if
// Description : Serial link and AES-core handshake bundle of the frame slave.
//               Serial side : ss, start, mosi (in)  / miso (out)
//               Core request: core_valid, core_data, core_key (out) /
//                             core_ready (in)
//               Core result : res_valid, res_data (in) / res_ready (out)
//               Status      : busy, done, frame_err (out)
//               The slave modport is the frame-slave view; the master modport
//               is the view of the serial master and AES core together.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_aes_frame_slave_if #(
    parameter int Nk = 4
) ();
    logic              ss;
    logic              start;
    logic              mosi;
    logic              miso;
    logic              core_valid;
    logic              core_ready;
    logic [127:0]      core_data;
    logic [32*Nk-1:0]  core_key;
    logic              res_valid;
    logic              res_ready;
    logic [127:0]      res_data;
    logic              busy;
    logic              done;
    logic              frame_err;

    modport slave (
        input  ss, start, mosi, core_ready, res_valid, res_data,
        output miso, core_valid, core_data, core_key, res_ready,
               busy, done, frame_err
    );

    modport master (
        output ss, start, mosi, core_ready, res_valid, res_data,
        input  miso, core_valid, core_data, core_key, res_ready,
               busy, done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_aes_frame_slave_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_shifter
// Description : W-bit shift register with parallel load, shifting toward the
//               MSB so bit W-1 is the first bit in and the first bit out.
//               Ports: clock, reset (async, active-low), load + load_data
//               (parallel load, wins over shift), shift_en + shift_in
//               (serial entry at bit 0), q (register contents).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_shifter #(
    parameter int W = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         shift_in,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_data;
        end else if (shift_en) begin
            r_q <= {r_q[W-2:0], shift_in};
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/spi_aes_frame_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_aes_frame_slave
// Description : Bit-per-clock serial slave in front of one AES unit. Receives
//               a {block, key} frame MSB first, offers it to the core over a
//               valid/ready handshake, then returns a start bit followed by
//               {result, key} MSB first on miso.
//               Ports: clock, reset (async, active-low), bus (slave modport of
//               spi_aes_frame_slave_if carrying the serial, core and status
//               signals).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_aes_frame_slave
    import aes_spi_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    spi_aes_frame_slave_if.slave  bus
);
    localparam int W  = frame_width(Nk);
    localparam int KW = 32 * Nk;

    // RX finishes when W bits are in; TX counts from 0 after emitting the MSB
    // on entry, so its final compare is one lower.
    localparam logic [c_CNT_W-1:0] c_RX_LAST = c_CNT_W'(W);
    localparam logic [c_CNT_W-1:0] c_TX_LAST = c_CNT_W'(W - 1);

    if (!nk_is_legal(Nk)) begin : g_bad_nk
        $error("spi_aes_frame_slave: Nk must be 4, 6 or 8");
    end

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_miso;
    logic                 r_core_valid;
    logic                 r_res_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_frame_err;

    logic [W-1:0]         w_rx_q;
    logic [W-1:0]         w_tx_q;
    logic                 w_rx_shift;
    logic                 w_tx_load;
    logic                 w_tx_shift;
    logic                 w_unused_tx;

    // Shift-enables mirror the FSM transitions below: nothing moves on the
    // cycle that aborts a frame or on the cycle that closes it.
    assign w_rx_shift = !bus.ss &&
                        (((r_state == ST_IDLE) && bus.start) ||
                         ((r_state == ST_RX) && (r_cnt != c_RX_LAST)));
    assign w_tx_load  = (r_state == ST_CORE_WAIT) && r_res_ready && bus.res_valid;
    assign w_tx_shift = !bus.ss &&
                        ((r_state == ST_TX_START) ||
                         ((r_state == ST_TX) && (r_cnt != c_TX_LAST)));

    spi_frame_shifter #(.W(W)) u_rx_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (w_rx_shift),
        .shift_in  (bus.mosi),
        .q         (w_rx_q)
    );

    spi_frame_shifter #(.W(W)) u_tx_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (w_tx_load),
        .load_data ({bus.res_data, w_rx_q[KW-1:0]}),
        .shift_en  (w_tx_shift),
        .shift_in  (1'b0),
        .q         (w_tx_q)
    );

    // Only the MSB of the transmit register is ever observed.
    assign w_unused_tx = ^w_tx_q[W-2:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_miso       <= 1'b0;
            r_core_valid <= 1'b0;
            r_res_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.ss) begin
                        r_state <= ST_RX;
                        r_cnt   <= c_CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_RX: begin
                    if (bus.ss) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                    end else if (r_cnt == c_RX_LAST) begin
                        r_state      <= ST_CORE_REQ;
                        r_core_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                // The core transaction runs to completion regardless of ss.
                ST_CORE_REQ: begin
                    if (r_core_valid && bus.core_ready) begin
                        r_state      <= ST_CORE_WAIT;
                        r_core_valid <= 1'b0;
                        r_res_ready  <= 1'b1;
                    end
                end
                ST_CORE_WAIT: begin
                    if (r_res_ready && bus.res_valid) begin
                        r_state     <= ST_TX_START;
                        r_res_ready <= 1'b0;
                        r_miso      <= c_START_BIT;
                        r_cnt       <= '0;
                    end
                end
                ST_TX_START: begin
                    if (bus.ss) begin
                        r_state     <= ST_IDLE;
                        r_miso      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_state <= ST_TX;
                        r_miso  <= w_tx_q[W-1];
                        r_cnt   <= '0;
                    end
                end
                ST_TX: begin
                    if (bus.ss) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_miso      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                    end else if (r_cnt == c_TX_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_miso  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_miso <= w_tx_q[W-1];
                        r_cnt  <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                    r_miso       <= 1'b0;
                    r_core_valid <= 1'b0;
                    r_res_ready  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // The receive register is already registered and frozen outside RX, so it
    // drives the core request fields directly.
    assign bus.core_data  = w_rx_q[W-1:KW];
    assign bus.core_key   = w_rx_q[KW-1:0];
    assign bus.core_valid = r_core_valid;
    assign bus.res_ready  = r_res_ready;
    assign bus.miso       = r_miso;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.frame_err  = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_aes_frame_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_aes_frame_slave
// Description : Directed bench for spi_aes_frame_slave. Three instances
//               (Nk = 4, 6, 8) share clock and reset; the bench plays both the
//               serial master and the AES core, using FIPS-197 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_aes_frame_slave;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]        ss_v         = '1;
    logic [2:0]        start_v      = '0;
    logic [2:0]        mosi_v       = '0;
    logic [2:0]        core_ready_v = '0;
    logic [2:0]        res_valid_v  = '0;
    logic [2:0][127:0] res_data_v   = '0;

    logic [2:0]        miso_o, cv_o, rr_o, busy_o, done_o, ferr_o;
    logic [2:0][127:0] data_o;
    logic [2:0][255:0] key_o;

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        spi_aes_frame_slave_if #(.Nk(4 + 2*i)) bus ();
        assign bus.ss         = ss_v[i];
        assign bus.start      = start_v[i];
        assign bus.mosi       = mosi_v[i];
        assign bus.core_ready = core_ready_v[i];
        assign bus.res_valid  = res_valid_v[i];
        assign bus.res_data   = res_data_v[i];
        assign miso_o[i]      = bus.miso;
        assign cv_o[i]        = bus.core_valid;
        assign rr_o[i]        = bus.res_ready;
        assign busy_o[i]      = bus.busy;
        assign done_o[i]      = bus.done;
        assign ferr_o[i]      = bus.frame_err;
        assign data_o[i]      = bus.core_data;
        assign key_o[i]       = 256'(bus.core_key);

        spi_aes_frame_slave #(.Nk(4 + 2*i)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
    end

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K4 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K6 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input int s, input string tag);
        check({tag, "_ctl"}, 384'({miso_o[s], cv_o[s], rr_o[s], busy_o[s], done_o[s], ferr_o[s]}), '0);
        check({tag, "_data"}, 384'(data_o[s]), '0);
        check({tag, "_key"}, 384'(key_o[s]), '0);
    endtask

    // Assert reset between clock edges and look at the outputs before the
    // next edge arrives.
    task automatic mid_reset(input int s, input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero(s, tag);
        res_valid_v[s]  = 1'b0;
        core_ready_v[s] = 1'b0;
        start_v[s]      = 1'b0;
        ss_v[s]         = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check({tag, "_idle"}, 384'(busy_o[s]), '0);
    endtask

    // One complete frame on instance s. Negative abort/spur indices disable
    // that feature; rst_pt 1 resets in CORE_WAIT, 2 resets at TX bit 30.
    task automatic run_frame(input int s, input logic [127:0] pt, input logic [255:0] key,
                             input logic [127:0] res, input int rdy_dly, input int res_dly,
                             input int rx_abort, input int tx_abort, input int spur,
                             input int rst_pt, input string tag);
        int kw, w, bad;
        logic [383:0] fr, exp, got;
        kw  = 32 * (4 + 2*s);
        w   = 128 + kw;
        fr  = (384'(pt) << kw) | 384'(key);
        exp = (384'(res) << kw) | 384'(key);
        got = '0;

        for (int k = 0; k < w; k++) begin
            ss_v[s]    = (k == rx_abort);
            start_v[s] = (k == 0) || (k == spur);
            mosi_v[s]  = fr[w-1-k];
            tick();
            if (k == rx_abort) begin
                start_v[s] = 1'b0;
                check({tag, "_err"}, 384'(ferr_o[s]), 1);
                check({tag, "_busy"}, 384'(busy_o[s]), 0);
                check({tag, "_miso"}, 384'(miso_o[s]), 0);
                ss_v[s] = 1'b1;
                tick();
                check({tag, "_err_pulse"}, 384'(ferr_o[s]), 0);
                return;
            end
        end
        start_v[s] = 1'b0;
        check({tag, "_cv_early"}, 384'(cv_o[s]), 0);
        tick();
        check({tag, "_cv"}, 384'(cv_o[s]), 1);
        check({tag, "_core_data"}, 384'(data_o[s]), 384'(pt));
        check({tag, "_core_key"}, 384'(key_o[s]), 384'(key));

        bad = 0;
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            if (cv_o[s] !== 1'b1 || data_o[s] !== pt || miso_o[s] !== 1'b0) bad++;
        end
        if (rdy_dly > 0) check({tag, "_req_hold"}, 384'(bad), 0);

        core_ready_v[s] = 1'b1;
        tick();
        core_ready_v[s] = 1'b0;
        check({tag, "_cv_drop"}, 384'(cv_o[s]), 0);
        check({tag, "_res_ready"}, 384'(rr_o[s]), 1);

        bad = 0;
        for (int i = 0; i < res_dly; i++) begin
            tick();
            if (rr_o[s] !== 1'b1 || miso_o[s] !== 1'b0 || busy_o[s] !== 1'b1) bad++;
        end
        if (res_dly > 0) check({tag, "_wait_hold"}, 384'(bad), 0);

        if (rst_pt == 1) begin
            mid_reset(s, tag);
            return;
        end

        res_data_v[s]  = res;
        res_valid_v[s] = 1'b1;
        tick();
        res_valid_v[s] = 1'b0;
        check({tag, "_start_bit"}, 384'(miso_o[s]), 1);
        check({tag, "_rr_drop"}, 384'(rr_o[s]), 0);

        for (int k = 0; k < w; k++) begin
            if (k == tx_abort) begin
                start_v[s] = 1'b0;
                ss_v[s]    = 1'b1;
                tick();
                check({tag, "_err"}, 384'(ferr_o[s]), 1);
                check({tag, "_miso"}, 384'(miso_o[s]), 0);
                check({tag, "_busy"}, 384'(busy_o[s]), 0);
                tick();
                check({tag, "_err_pulse"}, 384'(ferr_o[s]), 0);
                return;
            end
            if (rst_pt == 2 && k == 30) begin
                mid_reset(s, tag);
                return;
            end
            start_v[s] = (k == spur);
            tick();
            got[w-1-k] = miso_o[s];
        end
        start_v[s] = 1'b0;
        check({tag, "_response"}, got, exp);
        tick();
        check({tag, "_done"}, 384'(done_o[s]), 1);
        check({tag, "_end_busy"}, 384'(busy_o[s]), 0);
        check({tag, "_end_miso"}, 384'(miso_o[s]), 0);
        tick();
        check({tag, "_done_pulse"}, 384'(done_o[s]), 0);
        ss_v[s] = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        check_all_zero(0, "reset_nk4");
        check_all_zero(1, "reset_nk6");
        check_all_zero(2, "reset_nk8");
        reset = 1'b1;
        tick();

        run_frame(0, PT, K4, C4, 0, 0, -1, -1, -1, 0, "nk4");
        run_frame(1, PT, K6, C6, 0, 0, -1, -1, -1, 0, "nk6");
        run_frame(2, PT, K8, C8, 0, 0, -1, -1, -1, 0, "nk8");
        run_frame(0, PT, K4, C4, 10, 50, -1, -1, -1, 0, "backpressure");
        run_frame(0, PT, K4, C4, 0, 0, 100, -1, -1, 0, "rx_abort");
        run_frame(0, PT, K4, C4, 0, 0, -1, -1, -1, 0, "after_rx_abort");
        run_frame(1, PT, K6, C6, 0, 0, -1, 20, -1, 0, "tx_abort");
        run_frame(1, PT, K6, C6, 0, 0, -1, -1, -1, 0, "after_tx_abort");
        run_frame(2, PT, K8, C8, 0, 0, -1, -1, 50, 0, "spurious_start");
        run_frame(0, PT, K4, C4, 0, 3, -1, -1, -1, 1, "reset_core_wait");
        run_frame(0, PT, K4, C4, 0, 0, -1, -1, -1, 2, "reset_mid_tx");
        run_frame(0, PT, K4, C4, 2, 2, -1, -1, -1, 0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
